// File: rtl/user_cl_pkg.sv
// Shared definitions for the CL user compute blocks.
//   state_t             : packet summer FSM states
//   DEFAULT_TRAILER_TAG : default tag byte in bits [31:24] of a trailer word
//   HDR_N_*             : position of the operand count in a header word
//   TRL_*               : field positions inside a trailer word
//   make_trailer()      : packs {tag, n, carries} into a trailer word
package user_cl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_WAIT,
    OP_REQ,
    OP_WAIT,
    WR_SUM,
    WR_TRL
  } state_t;

  localparam logic [7:0]  DEFAULT_TRAILER_TAG = 8'hC5;

  localparam int unsigned HDR_N_LSB     = 0;
  localparam int unsigned HDR_N_W       = 8;

  localparam int unsigned TRL_CARRY_LSB = 0;
  localparam int unsigned TRL_CARRY_W   = 16;
  localparam int unsigned TRL_N_LSB     = 16;
  localparam int unsigned TRL_N_W       = 8;
  localparam int unsigned TRL_TAG_LSB   = 24;
  localparam int unsigned TRL_TAG_W     = 8;

  function automatic logic [31:0] make_trailer(
    input logic [TRL_TAG_W-1:0]   tag,
    input logic [TRL_N_W-1:0]     n,
    input logic [TRL_CARRY_W-1:0] carries
  );
    logic [31:0] w;
    w = '0;
    w[TRL_TAG_LSB   +: TRL_TAG_W]   = tag;
    w[TRL_N_LSB     +: TRL_N_W]     = n;
    w[TRL_CARRY_LSB +: TRL_CARRY_W] = carries;
    return w;
  endfunction

endpackage

// File: rtl/user_cl_packet_summer.sv
// Packet summer between the host-to-user and user-to-host command FIFOs.
// Pops a header (N = header[7:0]) and N operands, then pushes the wrapped
// 32-bit sum followed by a trailer {TRAILER_TAG, N, carries}.
// Ports:
//   clock       main CL clock (clk_main_a0)
//   reset       synchronous, active-high reset
//   data_empty  input FIFO empty
//   data_rd     input FIFO pop strobe (data valid on data_din next cycle)
//   data_din    input FIFO read data
//   data_full   output FIFO full
//   data_wr     output FIFO push strobe
//   data_dout   output FIFO write data
//   busy        high whenever the FSM is not idle
//   pkt_count   completed packet count, wraps at 2^16
module user_cl_packet_summer
  import user_cl_pkg::*;
#(
  parameter logic [7:0] TRAILER_TAG = DEFAULT_TRAILER_TAG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_empty,
  output logic        data_rd,
  input  logic [31:0] data_din,
  input  logic        data_full,
  output logic        data_wr,
  output logic [31:0] data_dout,
  output logic        busy,
  output logic [15:0] pkt_count
);

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  n_q;
  logic [7:0]  remaining_q;
  logic [31:0] acc_q;
  logic [15:0] carries_q;

  logic [7:0]  hdr_n;
  logic [32:0] add_full;
  logic [15:0] carries_upd;
  logic        last_op;

  assign hdr_n       = data_din[HDR_N_LSB +: HDR_N_W];
  assign add_full    = {1'b0, acc_q} + {1'b0, data_din};
  assign carries_upd = (add_full[32] && (carries_q != '1)) ? carries_q + 16'd1 : carries_q;
  assign last_op     = (remaining_q == 8'd1);

  // The strobes are decoded from the registered state and gated by the FIFO
  // flags of the same cycle, so a pop never meets an empty FIFO and a push
  // never meets a full one. data_dout, busy and pkt_count are flops.
  always_comb begin
    state_nxt = state;
    data_rd   = 1'b0;
    data_wr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!data_empty) begin
          data_rd   = 1'b1;
          state_nxt = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        state_nxt = (hdr_n == '0) ? WR_SUM : OP_REQ;
      end
      OP_REQ: begin
        if (!data_empty) begin
          data_rd   = 1'b1;
          state_nxt = OP_WAIT;
        end
      end
      OP_WAIT: begin
        state_nxt = last_op ? WR_SUM : OP_REQ;
      end
      WR_SUM: begin
        if (!data_full) begin
          data_wr   = 1'b1;
          state_nxt = WR_TRL;
        end
      end
      WR_TRL: begin
        if (!data_full) begin
          data_wr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // data_dout is loaded one state ahead: the sum when entering WR_SUM, the
  // trailer when leaving WR_SUM, so it is already stable while a full FIFO
  // holds the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      n_q         <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      carries_q   <= '0;
      data_dout   <= '0;
      busy        <= 1'b0;
      pkt_count   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      unique case (state)
        HDR_WAIT: begin
          n_q         <= hdr_n;
          remaining_q <= hdr_n;
          acc_q       <= '0;
          carries_q   <= '0;
          if (hdr_n == '0) begin
            data_dout <= '0;
          end
        end
        OP_WAIT: begin
          acc_q       <= add_full[31:0];
          carries_q   <= carries_upd;
          remaining_q <= remaining_q - 8'd1;
          if (last_op) begin
            data_dout <= add_full[31:0];
          end
        end
        WR_SUM: begin
          if (!data_full) begin
            data_dout <= make_trailer(TRAILER_TAG, n_q, carries_q);
          end
        end
        WR_TRL: begin
          if (!data_full) begin
            pkt_count <= pkt_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_user_cl_packet_summer.sv
// Self-checking bench for user_cl_packet_summer. Models both FIFOs with
// queues; expected results come from whole-packet arithmetic.
module tb_user_cl_packet_summer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        data_empty = 1'b1;
  logic        data_rd;
  logic [31:0] data_din = '0;
  logic        data_full = 1'b0;
  logic        data_wr;
  logic [31:0] data_dout;
  logic        busy;
  logic [15:0] pkt_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  logic [31:0] exp_q[$];
  int unsigned rd_cyc[$];
  int unsigned wr_cyc[$];
  int unsigned cyc = 0;
  logic        stall_empty = 1'b0;
  int unsigned exp_pkts = 0;

  user_cl_packet_summer #(.TRAILER_TAG(8'hC5)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_empty (data_empty),
    .data_rd    (data_rd),
    .data_din   (data_din),
    .data_full  (data_full),
    .data_wr    (data_wr),
    .data_dout  (data_dout),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    data_empty = stall_empty || (in_q.size() == 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // FIFO models plus protocol watch: strobes sampled mid-cycle, effects
  // applied just after the edge that consumes them.
  always begin : fifo_model
    logic rd_s, wr_s, rd_prev;
    logic [31:0] dout_s;
    rd_prev = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      rd_s   = data_rd;
      wr_s   = data_wr;
      dout_s = data_dout;
      if (rd_s) begin
        rd_cyc.push_back(cyc);
        check32("rd_when_empty", {31'd0, data_empty}, 32'd0);
        check32("rd_back_to_back", {31'd0, rd_prev}, 32'd0);
      end
      if (wr_s) begin
        wr_cyc.push_back(cyc);
        check32("wr_when_full", {31'd0, data_full}, 32'd0);
        check32("rd_and_wr", {31'd0, rd_s}, 32'd0);
      end
      rd_prev = rd_s;
      @(posedge clock);
      #1;
      if (rd_s && in_q.size() > 0) data_din = in_q.pop_front();
      if (wr_s) out_q.push_back(dout_s);
      refresh();
    end
  end

  // Reference: carries equal the number of 2^32 wraps of the exact total.
  task automatic add_expected(input logic [31:0] hdr, input logic [31:0] ops[$]);
    longint unsigned sum_all;
    longint unsigned wraps;
    logic [15:0] carries;
    sum_all = 0;
    foreach (ops[i]) sum_all += longint'(ops[i]);
    wraps   = sum_all >> 32;
    carries = (wraps > 65535) ? 16'hFFFF : wraps[15:0];
    exp_q.push_back(sum_all[31:0]);
    exp_q.push_back({8'hC5, hdr[7:0], carries});
    exp_pkts++;
  endtask

  task automatic add_pkt(input logic [31:0] hdr, input logic [31:0] ops[$]);
    in_q.push_back(hdr);
    foreach (ops[i]) in_q.push_back(ops[i]);
    add_expected(hdr, ops);
    refresh();
  endtask

  task automatic wait_out(input int unsigned n, input int unsigned budget, input bit rnd);
    int unsigned left;
    left = budget;
    while (out_q.size() < int'(n) && left > 0) begin
      if (rnd) begin
        data_full   = ($urandom_range(0, 3) == 0);
        stall_empty = ($urandom_range(0, 3) == 0);
        refresh();
      end
      tick();
      left--;
    end
    data_full   = 1'b0;
    stall_empty = 1'b0;
    refresh();
    total++;
    assert (out_q.size() >= int'(n)) else begin
      bad++;
      $error("FAIL wait_out observed=%0d expected=%0d", out_q.size(), n);
    end
  endtask

  task automatic drain(input string tag);
    repeat (3) tick();
    check32({tag, "_count"}, out_q.size(), exp_q.size());
    while (out_q.size() > 0 && exp_q.size() > 0) check32(tag, out_q.pop_front(), exp_q.pop_front());
    out_q.delete();
    exp_q.delete();
    check32({tag, "_pkt_count"}, {16'd0, pkt_count}, exp_pkts);
  endtask

  initial begin : stim
    logic [31:0] ops[$];
    logic [31:0] hold;
    int unsigned n;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    check32("rst_rd", {31'd0, data_rd}, 32'd0);
    check32("rst_wr", {31'd0, data_wr}, 32'd0);
    check32("rst_dout", data_dout, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_pkt_count", {16'd0, pkt_count}, 32'd0);

    // Basic packet; also the first output sequence check
    add_pkt(32'h0000_0003, '{32'd1, 32'd2, 32'd3});
    check32("t1_sum_exp", exp_q[0], 32'h0000_0006);
    check32("t1_trl_exp", exp_q[1], 32'hC503_0000);
    wait_out(2, 200, 1'b0);
    drain("t1");

    // Wrap with one carry
    add_pkt(32'h0000_0002, '{32'hFFFF_FFFF, 32'h0000_0002});
    wait_out(2, 200, 1'b0);
    drain("t2");

    // N=0, upper header bits ignored, exactly one pop
    rd_cyc.delete();
    ops.delete();
    add_pkt(32'hABCD_0000, ops);
    wait_out(2, 200, 1'b0);
    check32("t3_pops", rd_cyc.size(), 32'd1);
    drain("t3");

    // Latency with two back-to-back packets (N=2 then N=1)
    rd_cyc.delete();
    wr_cyc.delete();
    add_pkt(32'h0000_0002, '{32'h10, 32'h20});
    add_pkt(32'h0000_0001, '{32'h7});
    wait_out(4, 200, 1'b0);
    check32("lat_sum", wr_cyc[0] - rd_cyc[0], 32'd6);
    check32("lat_trl", wr_cyc[1] - rd_cyc[0], 32'd7);
    check32("lat_next_hdr", rd_cyc[3] - rd_cyc[0], 32'd8);
    drain("lat");

    // Empty for 8 cycles before each operand
    ops = '{32'd5, 32'd6, 32'd7};
    add_expected(32'h0000_0003, ops);
    in_q.push_back(32'h0000_0003);
    refresh();
    repeat (2) tick();
    foreach (ops[i]) begin
      repeat (8) begin
        tick();
        check32("empty_no_rd", {31'd0, data_rd}, 32'd0);
        check32("empty_busy", {31'd0, busy}, 32'd1);
      end
      in_q.push_back(ops[i]);
      refresh();
    end
    wait_out(2, 200, 1'b0);
    check32("t4_sum_exp", exp_q[0], 32'h0000_0012);
    drain("t4");

    // Output FIFO full for 10 cycles around the sum
    data_full = 1'b1;
    add_pkt(32'h0000_0001, '{32'h1234_5678});
    hold = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      tick();
      check32("full_no_wr", {31'd0, data_wr}, 32'd0);
      if (i >= 6) check32("full_dout_stable", data_dout, hold);
    end
    data_full = 1'b0;
    #1;
    check32("full_release_wr", {31'd0, data_wr}, 32'd1);
    check32("full_release_sum", data_dout, hold);
    tick();
    check32("full_trl_wr", {31'd0, data_wr}, 32'd1);
    check32("full_trl", data_dout, 32'hC501_0000);
    tick();
    check32("full_after_wr", {31'd0, data_wr}, 32'd0);
    drain("t5");

    // Reset after 2 of 4 operands, then a fresh packet
    in_q.push_back(32'h0000_0004);
    in_q.push_back(32'h0000_0AAA);
    in_q.push_back(32'h0000_0BBB);
    refresh();
    repeat (8) tick();
    in_q.delete();
    refresh();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    exp_pkts = 0;
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_pkt_count", {16'd0, pkt_count}, 32'd0);
    check32("abort_no_out", out_q.size(), 32'd0);
    add_pkt(32'h0000_0001, '{32'd9});
    wait_out(2, 200, 1'b0);
    check32("t6_sum_exp", exp_q[0], 32'h0000_0009);
    drain("t6");

    // N=255 with all-ones operands (every add after the first carries)
    ops.delete();
    repeat (255) ops.push_back(32'hFFFF_FFFF);
    add_pkt(32'h0000_00FF, ops);
    wait_out(2, 2000, 1'b0);
    check32("t7_trl_exp", exp_q[1], 32'hC5FF_00FE);
    drain("t7");

    // Random packets with random empty/full stalls
    for (int p = 0; p < 12; p++) begin
      n = $urandom_range(0, 10);
      ops.delete();
      for (int k = 0; k < int'(n); k++) ops.push_back($urandom());
      add_pkt({$urandom_range(0, 32'h00FF_FFFF), 8'(n)}, ops);
    end
    wait_out(24, 3000, 1'b1);
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
